// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath: mult/div FSM states,
// MDcontrol op codes and the default datapath word width.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/md_negate.sv
// Conditional two's-complement: result = en ? -value : value.
// Used for operand magnitudes and for the final sign correction.
module md_negate #(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] value,
    output logic [W-1:0] result
);

    assign result = en ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring), one bit per clock.
// Optional macro MULT_DIV_ZERO_SKIP_EN finishes trivially-zero requests early.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_t              state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]     acc_reg, acc_next;
    logic [WIDTH-1:0]       opnd_reg, opnd_next;
    logic                   op_reg, op_next;
    logic                   sign_q_reg, sign_q_next;
    logic                   sign_r_reg, sign_r_next;
    logic                   div0_reg, div0_next;
    logic [WIDTH-1:0]       hi_reg, hi_next;
    logic [WIDTH-1:0]       lo_reg, lo_next;

    logic [WIDTH-1:0]       abs_a, abs_b;
    logic [2*WIDTH-1:0]     mul_step, div_step;
    logic [WIDTH:0]         mul_add, mul_upper;
    logic [2*WIDTH:0]       mul_wide;
    logic [WIDTH:0]         rem_shift, rem_trial;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quot_fix, rem_fix;
    logic [WIDTH-1:0]       fix_hi, fix_lo;

    md_negate #(.W(WIDTH)) u_abs_a (
        .en     (a[WIDTH-1]),
        .value  (a),
        .result (abs_a)
    );

    md_negate #(.W(WIDTH)) u_abs_b (
        .en     (b[WIDTH-1]),
        .value  (b),
        .result (abs_b)
    );

    // Multiply step: the carry of the upper-half add becomes the new MSB after the shift.
    always_comb begin
        mul_add   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
        mul_upper = acc_reg[0] ? mul_add : {1'b0, acc_reg[2*WIDTH-1:WIDTH]};
        mul_wide  = {mul_upper, acc_reg[WIDTH-1:0]};
        mul_step  = mul_wide[2*WIDTH:1];
    end

    // Restoring divide step: acc holds {rem, quot}; quotient bits enter at the LSB.
    always_comb begin
        rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        rem_trial = rem_shift - {1'b0, opnd_reg};
        if (!rem_trial[WIDTH]) begin
            div_step = {rem_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end
    end

    md_negate #(.W(2*WIDTH)) u_fix_prod (
        .en     (sign_q_reg),
        .value  (acc_reg),
        .result (prod_fix)
    );

    md_negate #(.W(WIDTH)) u_fix_quot (
        .en     (sign_q_reg),
        .value  (acc_reg[WIDTH-1:0]),
        .result (quot_fix)
    );

    md_negate #(.W(WIDTH)) u_fix_rem (
        .en     (sign_r_reg),
        .value  (acc_reg[2*WIDTH-1:WIDTH]),
        .result (rem_fix)
    );

    assign fix_hi = (op_reg == MD_DIV) ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo = (op_reg == MD_DIV) ? quot_fix : prod_fix[WIDTH-1:0];

`ifdef MULT_DIV_ZERO_SKIP_EN
    logic zero_req;
    assign zero_req = (op == MD_MULT) ? ((a == '0) || (b == '0))
                                      : ((a == '0) && (b != '0));
`endif

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        opnd_next   = opnd_reg;
        op_next     = op_reg;
        sign_q_next = sign_q_reg;
        sign_r_next = sign_r_reg;
        div0_next   = div0_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next     = op;
                    sign_q_next = a[WIDTH-1] ^ b[WIDTH-1];
                    sign_r_next = a[WIDTH-1];
                    cnt_next    = '0;
                    div0_next   = 1'b0;
                    // Multiplier / dividend sits in the low half; the high half starts clear.
                    if (op == MD_DIV) begin
                        opnd_next = abs_b;
                        acc_next  = {{WIDTH{1'b0}}, abs_a};
                    end else begin
                        opnd_next = abs_a;
                        acc_next  = {{WIDTH{1'b0}}, abs_b};
                    end

                    if ((op == MD_DIV) && (b == '0)) begin
                        div0_next  = 1'b1;
                        state_next = DONE;
                    end
`ifdef MULT_DIV_ZERO_SKIP_EN
                    else if (zero_req) begin
                        hi_next    = '0;
                        lo_next    = '0;
                        state_next = DONE;
                    end
`endif
                    else begin
                        state_next = RUN;
                    end
                end
            end

            RUN: begin
                acc_next = (op_reg == MD_DIV) ? div_step : mul_step;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    cnt_next   = '0;
                    state_next = FIX;
                end
            end

            FIX: begin
                hi_next    = fix_hi;
                lo_next    = fix_lo;
                state_next = DONE;
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            op_reg     <= 1'b0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            div0_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            opnd_reg   <= opnd_next;
            op_reg     <= op_next;
            sign_q_reg <= sign_q_next;
            sign_r_reg <= sign_r_next;
            div0_reg   <= div0_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign div0 = div0_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: transaction-level latency/result model,
// per-cycle compare on the falling edge, and literal vectors pinning the model.
module tb_mult_div_unit;

    localparam int W = 32;
    localparam int NVEC = 12;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         op    = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct packed {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } vec_t;

    vec_t vecs [NVEC];

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Model state: a transaction completes lat edges after acceptance; done is
    // visible after edge lat-1, and the unit is idle again from edge lat.
    bit          mbusy    = 1'b0;
    int          k        = 0;
    int          lat      = 1;
    logic [31:0] res_hi   = '0;
    logic [31:0] res_lo   = '0;
    logic        res_div0 = 1'b0;
    logic [31:0] cur_hi   = '0;
    logic [31:0] cur_lo   = '0;
    logic        cur_div0 = 1'b0;

    always @(posedge clock or negedge reset) begin : model
        longint sa, sb, prod, quo, rem;
        bit     zero;
        if (!reset) begin
            mbusy    = 1'b0;
            k        = 0;
            cur_hi   = '0;
            cur_lo   = '0;
            cur_div0 = 1'b0;
        end else begin
            if (mbusy) begin
                k++;
                if (k == lat) mbusy = 1'b0;
            end else if (start) begin
                sa       = longint'($signed(a));
                sb       = longint'($signed(b));
                mbusy    = 1'b1;
                k        = 0;
                lat      = W + 2;
                cur_div0 = 1'b0;
                res_div0 = 1'b0;
                zero     = 1'b0;
                if (op == 1'b0) begin
                    prod   = sa * sb;
                    res_hi = prod[63:32];
                    res_lo = prod[31:0];
                    zero   = (sa == 0) || (sb == 0);
                end else if (sb == 0) begin
                    lat      = 1;
                    res_div0 = 1'b1;
                    res_hi   = cur_hi;
                    res_lo   = cur_lo;
                end else begin
                    quo    = sa / sb;
                    rem    = sa % sb;
                    res_hi = rem[31:0];
                    res_lo = quo[31:0];
                    zero   = (sa == 0);
                end
`ifdef MULT_DIV_ZERO_SKIP_EN
                if (zero) lat = 1;
`endif
            end
            if (mbusy && (k == lat - 1)) begin
                cur_hi   = res_hi;
                cur_lo   = res_lo;
                cur_div0 = res_div0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    int tidx = 0;

    always @(negedge clock) begin : compare
        logic exp_done;
        exp_done = mbusy && (k == lat - 1);
        chk("busy", 64'(busy), 64'(mbusy));
        chk("done", 64'(done), 64'(exp_done));
        chk("div0", 64'(div0), 64'(cur_div0));
        chk("hi",   64'(hi),   64'(cur_hi));
        chk("lo",   64'(lo),   64'(cur_lo));
        if (exp_done) begin
            $display("txn %0d: done hi=%h lo=%h div0=%0d", tidx, hi, lo, div0);
            if (tidx < NVEC) begin
                chk("model_hi",   64'(res_hi),   64'(vecs[tidx].hi));
                chk("model_lo",   64'(res_lo),   64'(vecs[tidx].lo));
                chk("model_div0", 64'(res_div0), 64'(vecs[tidx].div0));
            end
            tidx++;
        end
    end

    task automatic issue(input logic iop, input logic [31:0] ia, input logic [31:0] ib);
        @(posedge clock);
        #1;
        start = 1'b1;
        op    = iop;
        a     = ia;
        b     = ib;
        @(posedge clock);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = ~op;
    endtask

    task automatic run_vec(input int i);
        issue(vecs[i].op, vecs[i].a, vecs[i].b);
        repeat (36) @(posedge clock);
    endtask

    initial begin
        //               op    a              b              hi             lo             div0
        vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0671, 32'h0000_0030, 32'h0000_0011, 32'h0000_0022, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 1'b1};
        vecs[6]  = '{1'b0, 32'h0001_2345, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFEDC_BB00, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0};
        vecs[9]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0000, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0};

        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // A second start ten cycles into a running multiply must be ignored.
        issue(vecs[6].op, vecs[6].a, vecs[6].b);
        repeat (9) @(posedge clock);
        #1;
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (30) @(posedge clock);

        for (int i = 7; i < 11; i++) run_vec(i);

        // Abort a multiply mid-run with an asynchronous reset.
        issue(1'b0, 32'd5, 32'd6);
        repeat (14) @(posedge clock);
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        run_vec(11);
        repeat (3) @(posedge clock);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
